mem_noc_arb_2to1: RTL and testbench



---
 rtl/mem_noc_arb_2to1_pkg.sv | 18 +
 rtl/mem_noc_ord_fifo.sv | 55 +++++
 rtl/mem_noc_arb_2to1.sv | 75 +++++++
 tb/tb_mem_noc_arb_2to1.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_noc_arb_2to1_pkg.sv
// mem_noc_arb_2to1_pkg: memory bus payload types and arbiter configuration.
package mem_noc_arb_2to1_pkg;

   localparam int MEM_ARB_DEPTH = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } mem_resp_t;

endpackage

// File: rtl/mem_noc_ord_fifo.sv
// mem_noc_ord_fifo: small synchronous FIFO; push while full and pop while empty are ignored.
module mem_noc_ord_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      full    = cnt_q == FULL_CNT;
      empty   = cnt_q == '0;
      do_push = push & !full;
      do_pop  = pop & !empty;
      wr_d    = do_push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      rd_d    = do_pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      dout    = mem_q[rd_q];
      count   = cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/mem_noc_arb_2to1.sv
// mem_noc_arb_2to1: round-robin 2:1 arbiter for the memory valid/ready bus,
// with an order FIFO steering in-order responses back to the issuing master.
module mem_noc_arb_2to1
   import mem_noc_arb_2to1_pkg::*;
#(
   parameter int DEPTH = MEM_ARB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       m0_req_valid,
   output logic                       m0_req_ready,
   input  mem_req_t                   m0_req,
   output logic                       m0_resp_valid,
   input  logic                       m0_resp_ready,
   output mem_resp_t                  m0_resp,
   input  logic                       m1_req_valid,
   output logic                       m1_req_ready,
   input  mem_req_t                   m1_req,
   output logic                       m1_resp_valid,
   input  logic                       m1_resp_ready,
   output mem_resp_t                  m1_resp,
   output logic                       sl_req_valid,
   input  logic                       sl_req_ready,
   output mem_req_t                   sl_req,
   input  logic                       sl_resp_valid,
   output logic                       sl_resp_ready,
   input  mem_resp_t                  sl_resp,
   output logic [$clog2(DEPTH+1)-1:0] outstanding
);
   logic prio_q, prio_d, lock_q, lock_d, lock_id_q, lock_id_d;
   logic gnt, accept, resp_hs, full, empty, head;

   always_comb begin
      gnt           = lock_q ? lock_id_q : (m0_req_valid & m1_req_valid) ? prio_q : m1_req_valid;
      sl_req_valid  = (gnt ? m1_req_valid : m0_req_valid) & !full;
      sl_req        = gnt ? m1_req : m0_req;
      m0_req_ready  = sl_req_ready & !full & !gnt;
      m1_req_ready  = sl_req_ready & !full & gnt;
      accept        = sl_req_valid & sl_req_ready;
      lock_d        = lock_q ? !accept : sl_req_valid & !sl_req_ready;
      lock_id_d     = lock_q ? lock_id_q : gnt;
      prio_d        = accept ? !gnt : prio_q;
      m0_resp_valid = sl_resp_valid & !empty & !head;
      m1_resp_valid = sl_resp_valid & !empty & head;
      m0_resp       = sl_resp;
      m1_resp       = sl_resp;
      sl_resp_ready = !empty & (head ? m1_resp_ready : m0_resp_ready);
      resp_hs       = sl_resp_valid & sl_resp_ready;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prio_q    <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
      end else begin
         prio_q    <= prio_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   mem_noc_ord_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_ord (
      .clk   (clk),
      .rstn  (rstn),
      .push  (accept),
      .pop   (resp_hs),
      .din   (gnt),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );

endmodule

// File: tb/tb_mem_noc_arb_2to1.sv
// tb_mem_noc_arb_2to1: directed scenarios for the 2:1 memory arbiter.
module tb_mem_noc_arb_2to1;
   import mem_noc_arb_2to1_pkg::*;

   logic      clk = 1'b0;
   logic      rstn = 1'b0;
   logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
   logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
   logic      sl_req_valid, sl_req_ready, sl_resp_valid, sl_resp_ready;
   mem_req_t  m0_req, m1_req, sl_req;
   mem_resp_t m0_resp, m1_resp, sl_resp;
   logic [1:0] outstanding;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_noc_arb_2to1 #(.DEPTH(2)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
      .sl_req_valid(sl_req_valid), .sl_req_ready(sl_req_ready), .sl_req(sl_req),
      .sl_resp_valid(sl_resp_valid), .sl_resp_ready(sl_resp_ready), .sl_resp(sl_resp),
      .outstanding(outstanding)
   );

   function automatic mem_req_t mk_req(input logic [31:0] a);
      mk_req = '{addr: a, we: 1'b0, wdata: 32'h0, be: 4'hf};
   endfunction

   function automatic mem_resp_t mk_resp(input logic [31:0] d);
      mk_resp = '{rdata: d, err: 1'b0};
   endfunction

   task automatic idle();
      m0_req_valid = 0; m1_req_valid = 0; m0_req = mk_req(0); m1_req = mk_req(0);
      m0_resp_ready = 0; m1_resp_ready = 0;
      sl_req_ready = 0; sl_resp_valid = 0; sl_resp = mk_resp(0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle();
      rstn = 0;
      @(negedge clk);
      rstn = 1;
   endtask

   task automatic test_reset();
      idle();
      rstn = 0;
      #1;
      n_vec++;
      if ({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sl_req_valid, sl_resp_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_outs: got %b want 000000", {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sl_req_valid, sl_resp_ready});
      end
      n_vec++;
      if (outstanding !== 2'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
      @(negedge clk);
      rstn = 1;
   endtask

   task automatic test_single();
      logic [31:0] addrs [2] = '{32'h0000_0100, 32'h0000_0104};
      logic [31:0] datas [2] = '{32'hAAAA_0001, 32'hAAAA_0002};
      sl_req_ready = 1; m0_resp_ready = 1; m1_resp_ready = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         m0_req_valid = 1; m0_req = mk_req(addrs[i]);
         #1;
         n_vec++;
         if ({sl_req_valid, m0_req_ready, m1_req_ready} !== 3'b110 || sl_req.addr !== addrs[i]) begin
            n_err++;
            $display("FAIL single_req%0d: vld/rdy %b addr %h want 110 addr %h", i, {sl_req_valid, m0_req_ready, m1_req_ready}, sl_req.addr, addrs[i]);
         end
         @(posedge clk); #1;
         n_vec++;
         if (outstanding !== 2'(i + 1)) begin n_err++; $display("FAIL single_out%0d: got %0d want %0d", i, outstanding, i + 1); end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         m0_req_valid = 0; sl_resp_valid = 1; sl_resp = mk_resp(datas[i]);
         #1;
         n_vec++;
         if ({m0_resp_valid, m1_resp_valid, sl_resp_ready} !== 3'b101 || m0_resp.rdata !== datas[i]) begin
            n_err++;
            $display("FAIL single_resp%0d: vld/rdy %b data %h want 101 data %h", i, {m0_resp_valid, m1_resp_valid, sl_resp_ready}, m0_resp.rdata, datas[i]);
         end
         @(posedge clk); #1;
         n_vec++;
         if (outstanding !== 2'(1 - i)) begin n_err++; $display("FAIL single_drain%0d: got %0d want %0d", i, outstanding, 1 - i); end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_contention();
      apply_reset();
      m0_req_valid = 1; m0_req = mk_req(32'h200);
      m1_req_valid = 1; m1_req = mk_req(32'h300);
      sl_req_ready = 1; m0_resp_ready = 1; m1_resp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 4) begin m0_req_valid = 0; m1_req_valid = 0; end
         sl_resp_valid = i > 0;
         sl_resp = mk_resp(32'hC000_0000 + 32'(i));
         #1;
         if (i < 4) begin
            n_vec++;
            if ({m0_req_ready, m1_req_ready} !== ((i % 2) == 1 ? 2'b01 : 2'b10) ||
                sl_req.addr !== ((i % 2) == 1 ? 32'h300 : 32'h200)) begin
               n_err++;
               $display("FAIL cont_gnt%0d: rdy %b addr %h", i, {m0_req_ready, m1_req_ready}, sl_req.addr);
            end
         end
         if (i > 0) begin
            n_vec++;
            if ({m0_resp_valid, m1_resp_valid} !== (((i - 1) % 2) == 1 ? 2'b01 : 2'b10) ||
                m0_resp.rdata !== 32'hC000_0000 + 32'(i) || m1_resp.rdata !== 32'hC000_0000 + 32'(i)) begin
               n_err++;
               $display("FAIL cont_resp%0d: vld %b data %h/%h", i, {m0_resp_valid, m1_resp_valid}, m0_resp.rdata, m1_resp.rdata);
            end
         end
         @(posedge clk);
      end
      #1;
      n_vec++;
      if (outstanding !== 2'd0) begin n_err++; $display("FAIL cont_out: got %0d want 0", outstanding); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_lock();
      apply_reset();
      m1_req_valid = 1; m1_req = mk_req(32'h400); sl_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) begin m0_req_valid = 1; m0_req = mk_req(32'h410); end
         if (i == 3) sl_req_ready = 1;
         if (i == 4) m1_req_valid = 0;
         #1;
         n_vec++;
         if (sl_req_valid !== 1'b1 || sl_req.addr !== (i == 4 ? 32'h410 : 32'h400) ||
             {m0_req_ready, m1_req_ready} !== (i < 3 ? 2'b00 : i == 3 ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL lock_cyc%0d: vld %b addr %h rdy %b", i, sl_req_valid, sl_req.addr, {m0_req_ready, m1_req_ready});
         end
         @(posedge clk);
      end
      #1;
      n_vec++;
      if (outstanding !== 2'd2) begin n_err++; $display("FAIL lock_out: got %0d want 2", outstanding); end
   endtask

   task automatic test_full();
      @(negedge clk);
      m0_req_valid = 1; m0_req = mk_req(32'h500); sl_req_ready = 1;
      m0_resp_ready = 1; m1_resp_ready = 1;
      #1;
      n_vec++;
      if ({sl_req_valid, m0_req_ready} !== 2'b00) begin n_err++; $display("FAIL full_block: got %b want 00", {sl_req_valid, m0_req_ready}); end
      @(negedge clk);
      sl_resp_valid = 1; sl_resp = mk_resp(32'hD000_0000);
      #1;
      n_vec++;
      if ({sl_req_valid, m0_resp_valid, m1_resp_valid, sl_resp_ready} !== 4'b0011) begin
         n_err++;
         $display("FAIL full_pop: got %b want 0011", {sl_req_valid, m0_resp_valid, m1_resp_valid, sl_resp_ready});
      end
      @(posedge clk); #1;
      n_vec++;
      if (outstanding !== 2'd1) begin n_err++; $display("FAIL full_out1: got %0d want 1", outstanding); end
      @(negedge clk);
      sl_resp_valid = 0;
      #1;
      n_vec++;
      if ({sl_req_valid, m0_req_ready} !== 2'b11 || sl_req.addr !== 32'h500) begin
         n_err++;
         $display("FAIL full_present: got %b addr %h want 11 addr 500", {sl_req_valid, m0_req_ready}, sl_req.addr);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         m0_req_valid = 0; sl_resp_valid = 1;
         #1;
         n_vec++;
         if ({m0_resp_valid, m1_resp_valid} !== 2'b10) begin n_err++; $display("FAIL full_drain%0d: got %b want 10", i, {m0_resp_valid, m1_resp_valid}); end
      end
      @(posedge clk); #1;
      n_vec++;
      if (outstanding !== 2'd0) begin n_err++; $display("FAIL full_out0: got %0d want 0", outstanding); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_backpressure_wrap();
      @(negedge clk);
      sl_resp_valid = 1; sl_resp = mk_resp(32'hE000_0000); m0_resp_ready = 1; m1_resp_ready = 1;
      #1;
      n_vec++;
      if ({sl_resp_ready, m0_resp_valid, m1_resp_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL empty_resp: got %b want 000", {sl_resp_ready, m0_resp_valid, m1_resp_valid});
      end
      @(negedge clk);
      sl_resp_valid = 0; m1_req_valid = 1; m1_req = mk_req(32'h600); sl_req_ready = 1;
      @(negedge clk);
      m1_req_valid = 0; sl_resp_valid = 1; m1_resp_ready = 0;
      #1;
      n_vec++;
      if ({sl_resp_ready, m0_resp_valid, m1_resp_valid} !== 3'b001) begin
         n_err++;
         $display("FAIL bp_hold: got %b want 001", {sl_resp_ready, m0_resp_valid, m1_resp_valid});
      end
      @(posedge clk); #1;
      n_vec++;
      if (outstanding !== 2'd1) begin n_err++; $display("FAIL bp_out: got %0d want 1", outstanding); end
      @(negedge clk);
      m1_resp_ready = 1;
      #1;
      n_vec++;
      if (sl_resp_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", sl_resp_ready); end
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         m0_req_valid = i < 10 && (i % 2) == 0;
         m1_req_valid = i < 10 && (i % 2) == 1;
         m0_req = mk_req(32'h700 + 32'(i * 4));
         m1_req = mk_req(32'h700 + 32'(i * 4));
         sl_resp_valid = i > 0;
         sl_resp = mk_resp(32'hB000_0000 + 32'(i));
         #1;
         if (i < 10) begin
            n_vec++;
            if ({m0_req_ready, m1_req_ready} !== ((i % 2) == 1 ? 2'b01 : 2'b10)) begin
               n_err++;
               $display("FAIL wrap_gnt%0d: got %b", i, {m0_req_ready, m1_req_ready});
            end
         end
         if (i > 0) begin
            n_vec++;
            if ({m0_resp_valid, m1_resp_valid, sl_resp_ready} !== (((i - 1) % 2) == 1 ? 3'b011 : 3'b101)) begin
               n_err++;
               $display("FAIL wrap_resp%0d: got %b", i, {m0_resp_valid, m1_resp_valid, sl_resp_ready});
            end
         end
      end
      @(posedge clk); #1;
      n_vec++;
      if (outstanding !== 2'd0) begin n_err++; $display("FAIL wrap_out: got %0d want 0", outstanding); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      m0_req_valid = 1; m0_req = mk_req(32'h800); sl_req_ready = 1;
      @(negedge clk);
      m0_req = mk_req(32'h810); m1_req_valid = 1; m1_req = mk_req(32'h820); sl_req_ready = 0;
      #1;
      n_vec++;
      if (sl_req.addr !== 32'h820) begin n_err++; $display("FAIL rst_pre_gnt: got %h want 820", sl_req.addr); end
      @(posedge clk); #1;
      n_vec++;
      if (outstanding !== 2'd1) begin n_err++; $display("FAIL rst_pre_out: got %0d want 1", outstanding); end
      @(negedge clk);
      #2;
      idle();
      rstn = 0;
      #1;
      n_vec++;
      if (outstanding !== 2'd0 ||
          {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sl_req_valid, sl_resp_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL rst_async: out %0d flags %b want 0 000000", outstanding,
                  {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sl_req_valid, sl_resp_ready});
      end
      @(negedge clk);
      rstn = 1;
      m0_req_valid = 1; m0_req = mk_req(32'h900); m1_req_valid = 1; m1_req = mk_req(32'h910); sl_req_ready = 1;
      #1;
      n_vec++;
      if ({m0_req_ready, m1_req_ready} !== 2'b10 || sl_req.addr !== 32'h900) begin
         n_err++;
         $display("FAIL rst_post_gnt: rdy %b addr %h want 10 addr 900", {m0_req_ready, m1_req_ready}, sl_req.addr);
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_lock();
      test_full();
      test_backpressure_wrap();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
